divider_unit: RTL and testbench
===============================

// Module: divider_unit
// PURPOSE
//   Multi-cycle restoring integer divider, unsigned or signed per operation.
//   Accepts a dividend/divisor pair on a start pulse and returns quotient and remainder
//   after a fixed latency, with a done pulse. Used wherever the datapath needs a
//   division result (e.g. value-to-digit conversion for segment displays).
// PARAMETERS
//   WIDTH  32  operand/result width in bits (WIDTH >= 2)
// PORTS
//   clk          in   1      system clock, rising-edge
//   rst          in   1      asynchronous, active-high reset
//   start        in   1      begin operation; sampled on clk edge when busy==0
//   mode         in   1      0 = unsigned, 1 = signed two's complement
//   dividend     in   WIDTH  dividend, sampled with start
//   divisor      in   WIDTH  divisor, sampled with start
//   quotient     out  WIDTH  result quotient, registered, held until next result
//   remainder    out  WIDTH  result remainder, registered, held until next result
//   busy         out  1      high while an operation is in progress
//   done         out  1      one-cycle pulse: quotient/remainder valid and updated
//   div_by_zero  out  1      registered with the result; 1 if divisor was 0
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-high (rst).
//   - Reset: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, FSM to IDLE.
//   - FSM states: IDLE -> RUN -> FINISH -> IDLE.
//   - IDLE: start=1 at edge N latches mode, operand magnitudes, sign of dividend
//     (rem_neg) and sign of quotient (q_neg = sign(dividend) XOR sign(divisor)).
//     The sign flags are 0 in unsigned mode. The counter loads WIDTH. Go to RUN
//     with busy=1.
//   - Signed magnitude = two's-complement negate when MSB=1. -2^(WIDTH-1) maps to
//     the unsigned value 2^(WIDTH-1). Use WIDTH-bit unsigned magnitudes throughout.
//   - RUN: one restoring step per cycle. The partial remainder (WIDTH+1 bits) shifts
//     left and takes in the next dividend MSB. Subtract the divisor magnitude. If the
//     result is non-negative, keep it and shift in quotient bit 1; otherwise restore
//     and shift in 0. WIDTH steps occur on edges N+1..N+WIDTH.
//   - FINISH (edge N+WIDTH+1): quotient = q_neg ? -q : q and
//     remainder = rem_neg ? -r : r. Set done=1 for exactly that cycle and busy=0.
//     Return to IDLE.
//   - Latency: start at edge N gives results/done visible after edge N+WIDTH+1
//     (33 cycles at WIDTH=32). A new start is accepted in the cycle done is high.
//   - Signed semantics: the quotient truncates toward zero. The remainder has the sign
//     of the dividend, so dividend = quotient*divisor + remainder.
//   - Overflow: signed -2^(WIDTH-1) / -1 gives quotient = -2^(WIDTH-1) (wraps) and
//     remainder = 0. No flag is raised.
//   - Divide by zero (divisor==0, either mode): skip RUN. At edge N+1 set
//     quotient = all ones and remainder = dividend unchanged. Set div_by_zero=1,
//     done=1, busy high only for that single cycle.
//   - div_by_zero updates only with a new result and clears on the next nonzero result.
//   - start while busy=1 is ignored. Operand/mode changes during RUN do not affect
//     the result.
//   - rst asserted mid-operation aborts immediately. All outputs return to reset values.
//     No done is produced for the aborted operation.
//   - quotient/remainder change only at FINISH or on a div-by-zero completion.
// TESTING
//   - mode=0, 50/3 -> after 33 cycles done=1, quotient=16, remainder=2, div_by_zero=0
//   - mode=1, -50/3 -> quotient=-16, remainder=-2; mode=1, 50/-3 -> quotient=-16, remainder=2
//   - mode=0, 50/0 -> done after 1 cycle, quotient=32'hFFFFFFFF, remainder=50, div_by_zero=1
//   - mode=1, 32'h80000000 / -1 -> quotient=32'h80000000, remainder=0;
//     mode=0, 32'hFFFFFFFF / 2 -> quotient=32'h7FFFFFFF, remainder=1
//   - start 1000/7, pulse start again at cycle 5 (ignored) -> result 142 r 6 at cycle 33;
//     start again, assert rst at cycle 10 -> outputs 0, no done
//   - back-to-back: start re-asserted in the done cycle -> second result exactly 33 cycles later

Source files
------------

// File: rtl/divider_unit.sv
// divider_unit: multi-cycle restoring divider, unsigned or signed per operation.
// One quotient bit per cycle over WIDTH cycles, plus one cycle for sign fix-up.
// A zero divisor skips the iteration and completes on the next edge.
module divider_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pr;       // partial remainder (always < divisor magnitude)
    logic [WIDTH-1:0] qr;       // dividend bits shift out of the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dsr;      // divisor magnitude
    logic             rem_neg;
    logic             q_neg;
    logic             dz;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             sa, sb;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign sa      = mode & dividend[WIDTH-1];
    assign sb      = mode & divisor[WIDTH-1];
    assign shifted = {pr, qr[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr};
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: zero divisor jumps straight to FINISH; RUN ends after WIDTH steps.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (divisor == '0) ? FINISH : RUN;
            RUN:     if (cnt == CW'(1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, restoring iteration, result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            pr          <= '0;
            qr          <= '0;
            dsr         <= '0;
            rem_neg     <= 1'b0;
            q_neg       <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    dz      <= (divisor == '0);
                    // on divide-by-zero the raw dividend is parked in qr to become the remainder
                    qr      <= (divisor == '0) ? dividend : mag(dividend, mode);
                    dsr     <= mag(divisor, mode);
                    pr      <= '0;
                    cnt     <= CW'(WIDTH);
                    rem_neg <= sa;
                    q_neg   <= sa ^ sb;
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (!diff[WIDTH]) begin
                        pr <= diff[WIDTH-1:0];
                        qr <= {qr[WIDTH-2:0], 1'b1};
                    end else begin
                        pr <= shifted[WIDTH-1:0];
                        qr <= {qr[WIDTH-2:0], 1'b0};
                    end
                end
                FINISH: begin
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= qr;
                    end else begin
                        quotient  <= q_neg   ? -qr : qr;
                        remainder <= rem_neg ? -pr : pr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: directed vectors with hand-computed results for divider_unit.
module tb_divider_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient, remainder;
    logic        busy, done, div_by_zero;

    int nvec = 0;
    int nerr = 0;

    divider_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, scramble the inputs after acceptance, wait for done.
    // Returns in the done cycle, so back-to-back calls restart in that cycle.
    task automatic run_op(input string tag, input logic m, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz, input int elat);
        int lat;
        @(negedge clk);
        start = 1'b1; mode = m; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; dividend = ~a; divisor = 32'd5;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " lat"}, 32'(lat), 32'(elat));
        chk({tag, " q"}, quotient, eq);
        chk({tag, " r"}, remainder, er);
        chk({tag, " dz"}, {31'd0, div_by_zero}, {31'd0, edz});
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        int ndone;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst q", quotient, 32'd0);
        chk("rst r", remainder, 32'd0);
        chk("rst flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op("u50/3", 1'b0, 32'd50, 32'd3, 32'd16, 32'd2, 1'b0, 33);
        @(posedge clk); #1;
        chk("done pulse", {31'd0, done}, 32'd0);
        // back-to-back from here on: each call starts in the previous done cycle
        run_op("s-50/3", 1'b1, -32'sd50, 32'd3, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 1'b0, 33);
        run_op("s50/-3", 1'b1, 32'd50, -32'sd3, 32'hFFFF_FFF0, 32'd2, 1'b0, 33);
        run_op("u50/0", 1'b0, 32'd50, 32'd0, 32'hFFFF_FFFF, 32'd50, 1'b1, 1);
        run_op("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_op("uFF/2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 33);
        run_op("s-7/-2", 1'b1, -32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("s-7/0", 1'b1, -32'sd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1);
        run_op("u5/7", 1'b0, 32'd5, 32'd7, 32'd0, 32'd5, 1'b0, 33);
        run_op("u0/9", 1'b0, 32'd0, 32'd9, 32'd0, 32'd0, 1'b0, 33);

        // start pulsed while busy is ignored
        @(negedge clk);
        start = 1'b1; mode = 1'b0; dividend = 32'd1000; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 4) begin start = 1'b1; dividend = 32'd9; divisor = 32'd3; end
            if (cyc == 5) start = 1'b0;
        end
        chk("ign lat", 32'(cyc), 32'd33);
        chk("ign q", quotient, 32'd142);
        chk("ign r", remainder, 32'd6);

        // reset mid-operation aborts without a done
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort q", quotient, 32'd0);
        chk("abort r", remainder, 32'd0);
        chk("abort flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort no done", 32'(ndone), 32'd0);
        chk("abort hold q", quotient, 32'd0);

        // operation after the abort still works
        run_op("u100/10", 1'b0, 32'd100, 32'd10, 32'd10, 32'd0, 1'b0, 33);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
